// File: rtl/msg_route_ctrl.sv
// Routing controller for a three-way message splitter: buffers one upstream
// message, steers it by its destination field and keeps drop/timeout statistics.
module msg_route_ctrl #(
  parameter int unsigned WID = 132,
  parameter int unsigned TOW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [WID-1:0] msgin,
  output logic           msginack,
  output logic [WID-1:0] msgout,
  output logic [1:0]     sel,
  input  logic           splitack,
  input  logic           enable,
  input  logic [TOW-1:0] timeout_lim,
  output logic           busy,
  output logic [15:0]    drop_cnt,
  output logic [15:0]    tmo_cnt
);

  localparam int unsigned CW = 16;
  localparam int unsigned DW = 2;
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t         state, state_d;
  logic [WID-1:0] msgout_d;
  logic [DW-1:0]  sel_d;
  logic           busy_d;
  logic [TOW-1:0] timer, timer_d;
  logic [CW-1:0]  drop_d, tmo_d;

  logic [DW-1:0]  in_dest;
  logic           in_valid;
  logic           expire;

  assign in_dest  = msgin[WID-2 -: DW];
  assign in_valid = enable && msgin[WID-1];
  assign expire   = (timeout_lim != '0) && (timer == TOW'(timeout_lim - TOW'(1)));

  // msgout doubles as the message buffer; it is only non-zero while in SEND.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      msgout   <= '0;
      sel      <= '0;
      busy     <= 1'b0;
      timer    <= '0;
      drop_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      state    <= state_d;
      msgout   <= msgout_d;
      sel      <= sel_d;
      busy     <= busy_d;
      timer    <= timer_d;
      drop_cnt <= drop_d;
      tmo_cnt  <= tmo_d;
    end
  end

  always_comb begin
    state_d  = state;
    msgout_d = msgout;
    timer_d  = timer;
    drop_d   = drop_cnt;
    tmo_d    = tmo_cnt;
    msginack = 1'b0;
    sel_d    = '0;
    busy_d   = 1'b0;

    case (state)
      IDLE: begin
        if (in_valid) begin
          msginack = 1'b1;
          if (in_dest != '0) begin
            state_d  = SEND;
            msgout_d = msgin;
            timer_d  = '0;
          end else if (drop_cnt != CNT_MAX) begin
            drop_d = drop_cnt + CW'(1);
          end
        end
      end
      SEND: begin
        // An ack always wins over a coinciding timeout expiry.
        if (splitack) begin
          state_d = IDLE;
          if (in_valid) begin
            msginack = 1'b1;
            if (in_dest != '0) begin
              state_d  = SEND;
              msgout_d = msgin;
              timer_d  = '0;
            end else if (drop_cnt != CNT_MAX) begin
              drop_d = drop_cnt + CW'(1);
            end
          end
        end else if (expire) begin
          state_d = IDLE;
          if (tmo_cnt != CNT_MAX) begin
            tmo_d = tmo_cnt + CW'(1);
          end
        end else begin
          timer_d = timer + TOW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Presentation outputs follow the next state so they change only at an edge.
    if (state_d == SEND) begin
      sel_d  = msgout_d[WID-2 -: DW];
      busy_d = 1'b1;
    end else begin
      msgout_d = '0;
    end
  end

endmodule

// File: doc/msg_route_ctrl.md
# msg_route_ctrl

Routing controller that feeds a three-way message splitter. It captures one valid message from the upstream bus into a single-entry buffer, decodes its destination field, and drives the splitter's `sel` and message input. It holds the message until the selected leg acknowledges, or drops it after a programmable timeout. It sits between the roubus upstream link and the splitter and keeps saturating drop and timeout statistics.

## Interface
- `WID`, 132: message width; bit `WID-1` is the valid flag, bits `WID-2:WID-3` are the destination.
- `TOW`, 8: width of the timeout counter and of `timeout_lim`.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `msgin`  in  WID  upstream message; valid when `msgin[WID-1]==1`.
- `msginack`  out  1  one-cycle pulse in the cycle `msgin` is captured.
- `msgout`  out  WID  message to the splitter.
- `sel`  out  2  splitter select (1=a, 2=b, 3=c, 0=none).
- `splitack`  in  1  ack returned by the splitter for the current `sel`.
- `enable`  in  1  when 0, no new capture; an in-flight message still completes.
- `timeout_lim`  in  TOW  cycles to wait for `splitack`; 0 disables the timeout.
- `busy`  out  1  high while in SEND.
- `drop_cnt`  out  16  saturating count of messages dropped for destination 0.
- `tmo_cnt`  out  16  saturating count of messages dropped on timeout.

## Operation
- States: IDLE, SEND.
- All outputs are registered, except `msginack`, which is decoded combinationally from state and inputs.
- IDLE behaviour:
  - `sel`=0, `msgout`=0, `busy`=0.
  - Capture happens when `enable && msgin[WID-1]`. The same cycle raises `msginack` and registers `msgin` into `buf`.
  - Destination `d=msgin[WID-2:WID-3]`.
  - If d≠0: go to SEND and clear the timer.
  - If d==0: discard, increment `drop_cnt`, stay in IDLE.
- SEND behaviour:
  - `msgout`=`buf`, `sel`=`buf` destination, `busy`=1.
  - The timer increments every cycle without `splitack`.
- SEND exits:
  - `splitack`=1: the message is complete. If `enable && msgin[WID-1]` in that same cycle, the next message is captured back-to-back (`msginack`=1). With d≠0, stay in SEND, reload `buf`, clear the timer. With d==0, count a drop and go to IDLE. With no new message, go to IDLE.
  - `timeout_lim`≠0, timer==`timeout_lim`-1, and no `splitack`: drop `buf`, increment `tmo_cnt`, go to IDLE. No capture happens in that cycle.
- Simultaneous `splitack` and timeout expiry: the ack wins and no timeout is counted.
- `enable` falling in SEND does not abort; once the message completes, the block stays in IDLE.
- Counters saturate at 16'hFFFF and never wrap.
- `timeout_lim` is sampled every cycle. A change mid-SEND takes effect against the current timer value. If the timer is already ≥ the new limit, there is no timeout until the timer wraps at 2^TOW. Software must change the limit only while `busy`=0.

## Timing
- Reset values: state=IDLE, `buf`=0, `msgout`=0, `sel`=0, `busy`=0, timer=0, `drop_cnt`=0, `tmo_cnt`=0, `msginack`=0.
- Reset asserted mid-SEND aborts the message with no counter update.
- Latency: a message captured at edge N is presented (`sel`/`msgout`) after edge N, so it is visible in cycle N+1.
- Earliest completion is an ack in cycle N+1, giving 1 message/cycle sustained with back-to-back capture.
- Timeout: with limit L, the message is presented in cycles N+1..N+L, and state=IDLE after edge N+L.
- `msginack` is high only in a cycle where capture occurs, never two cycles for one message. Upstream must hold `msgin` until `msginack`.
- `sel` changes only at a clock edge and stays stable for the whole SEND of a message.

## Test plan
- Reset then single message: `msgin`={valid=1, d=2, payload=0xABC}, `splitack` high 3 cycles after present → `msginack` one pulse, `sel`=2 for 3 cycles, then `sel`=0, `busy`=0, both counters 0.
- Back-to-back: four messages with d=1,3,2,1 and `splitack` tied 1 → four consecutive `msginack` cycles, `sel` sequence 1,3,2,1 on consecutive cycles, no IDLE gap.
- Destination 0: three messages with d=0 → three `msginack` pulses, `sel` stays 0, `drop_cnt`=3.
- Timeout: `timeout_lim`=5, d=3, `splitack`=0 → `sel`=3 for exactly 5 cycles, then 0, `tmo_cnt`=1. Repeat with the ack arriving in the 5th cycle → `tmo_cnt` stays 1.
- Enable and reset: drop `enable` during SEND → current message completes on ack, no new capture while valid is held, resume on `enable`=1. Assert `rst` mid-SEND → all outputs 0 immediately (asynchronously).
- Saturation: force 65537 d=0 messages → `drop_cnt`=16'hFFFF.
